// File: rtl/subtrator_serial_8bits.sv
`default_nettype none
// ============================================================================
// Module   : subtrator_serial_8bits
// Brief    : Bit-serial subtractor with borrow, LSB first, start/busy/done
//            handshake. Computes S = A - B - Bin over WIDTH clock cycles.
// Revision : 1.0 - initial release
// ============================================================================
module subtrator_serial_8bits #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Bout,
    output logic             V,
    output logic             Z
);

    localparam int                 c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_br;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_a_msb;
    logic               r_b_msb;

    logic               w_d;
    logic               w_br_nxt;
    logic [WIDTH-1:0]   w_res_nxt;
    logic               w_last;
    logic               w_accept;

    // One full-subtractor cell, reused every cycle on the operand LSBs.
    assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_nxt  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};
    assign w_last    = (r_cnt == c_LAST);
    assign w_accept  = (r_state == IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            S       <= '0;
            Bout    <= 1'b0;
            V       <= 1'b0;
            Z       <= 1'b0;
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= B;
            r_res   <= '0;
            r_br    <= Bin;
            r_cnt   <= '0;
            r_a_msb <= A[WIDTH-1];
            r_b_msb <= B[WIDTH-1];
        end else if (r_state == SHIFT) begin
            r_a   <= {1'b0, r_a[WIDTH-1:1]};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
            r_res <= w_res_nxt;
            r_br  <= w_br_nxt;
            r_cnt <= r_cnt + c_ONE;
            // w_d is the result MSB on the final bit, so the flags need no extra cycle.
            if (w_last) begin
                S    <= w_res_nxt;
                Bout <= w_br_nxt;
                V    <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
                Z    <= (w_res_nxt == '0);
            end
        end
    end

endmodule
`default_nettype wire
